// File: rtl/nor_cmd_seq.sv
// NOR command sequencer: expands one high-level operation into the JEDEC unlock/command
// write sequence on a pipelined wishbone master, waits on RY/BY#, and verifies programs.
module nor_cmd_seq #(
   parameter int unsigned ADDRBITS       = 26,
   parameter int unsigned DATABITS       = 16,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [ADDRBITS-1:0] cmd_addr_i,
   input  logic [DATABITS-1:0] cmd_data_i,
   output logic                done_o,
   output logic [1:0]          status_o,
   output logic                busy_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [ADDRBITS-1:0] wbm_adr_o,
   output logic [DATABITS-1:0] wbm_dat_o,
   input  logic [DATABITS-1:0] wbm_dat_i,
   input  logic                wbm_ack_i,
   input  logic                wbm_stall_i,
   input  logic                wbm_err_i,
   input  logic                nor_ry_i
);

   typedef enum logic [2:0] {
      StIdle, StIssue, StWaitAck, StSettle, StPoll, StVrdIssue, StVrdAck, StDone
   } state_e;

   localparam logic [1:0] OpProg  = 2'd0;
   localparam logic [1:0] OpSect  = 2'd1;
   localparam logic [1:0] OpReset = 2'd3;

   localparam logic [1:0] StatOk      = 2'd0;
   localparam logic [1:0] StatTimeout = 2'd1;
   localparam logic [1:0] StatBusErr  = 2'd2;
   localparam logic [1:0] StatVerify  = 2'd3;

   localparam logic [ADDRBITS-1:0] AdrA = ADDRBITS'(12'h555);
   localparam logic [ADDRBITS-1:0] AdrB = ADDRBITS'(12'h2AA);
   localparam logic [31:0]         SettleLast = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0]         TimeoutLast = TIMEOUT_CYCLES - 32'd1;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [ADDRBITS-1:0] addr_q, addr_d;
   logic [DATABITS-1:0] data_q, data_d;
   logic [2:0]          step_q, step_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [1:0]          status_q, status_d;

   logic [ADDRBITS-1:0] step_adr;
   logic [DATABITS-1:0] step_dat;
   logic                last_step;

   // Command tables, indexed by the latched op and the current step.
   always_comb begin
      step_adr  = '0;
      step_dat  = '0;
      last_step = 1'b0;
      case (op_q)
         OpProg: begin
            case (step_q)
               3'd0:    begin step_adr = AdrA; step_dat = DATABITS'(8'hAA); end
               3'd1:    begin step_adr = AdrB; step_dat = DATABITS'(8'h55); end
               3'd2:    begin step_adr = AdrA; step_dat = DATABITS'(8'hA0); end
               default: begin step_adr = addr_q; step_dat = data_q; last_step = 1'b1; end
            endcase
         end
         OpReset: begin
            step_dat  = DATABITS'(8'hF0);
            last_step = 1'b1;
         end
         default: begin
            case (step_q)
               3'd0:    begin step_adr = AdrA; step_dat = DATABITS'(8'hAA); end
               3'd1:    begin step_adr = AdrB; step_dat = DATABITS'(8'h55); end
               3'd2:    begin step_adr = AdrA; step_dat = DATABITS'(8'h80); end
               3'd3:    begin step_adr = AdrA; step_dat = DATABITS'(8'hAA); end
               3'd4:    begin step_adr = AdrB; step_dat = DATABITS'(8'h55); end
               default: begin
                  step_adr  = (op_q == OpSect) ? addr_q : AdrA;
                  step_dat  = (op_q == OpSect) ? DATABITS'(8'h30) : DATABITS'(8'h10);
                  last_step = 1'b1;
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         op_q     <= 2'd0;
         addr_q   <= '0;
         data_q   <= '0;
         step_q   <= 3'd0;
         cnt_q    <= 32'd0;
         status_q <= StatOk;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      data_d   = data_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      if (wbm_cyc_o && wbm_err_i) begin
         state_d  = StDone;
         status_d = StatBusErr;
         cnt_d    = 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid_i) begin
                  op_d    = cmd_op_i;
                  addr_d  = cmd_addr_i;
                  data_d  = cmd_data_i;
                  step_d  = 3'd0;
                  cnt_d   = 32'd0;
                  state_d = StIssue;
               end
            end
            StIssue: if (!wbm_stall_i) state_d = StWaitAck;
            StWaitAck: begin
               if (wbm_ack_i) begin
                  if (!last_step) begin
                     step_d  = step_q + 3'd1;
                     state_d = StIssue;
                  end else if (op_q == OpReset) begin
                     status_d = StatOk;
                     state_d  = StDone;
                  end else begin
                     cnt_d   = 32'd0;
                     state_d = StSettle;
                  end
               end
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  cnt_d   = 32'd0;
                  state_d = StPoll;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            StPoll: begin
               // Ready takes priority over a coincident timeout.
               if (nor_ry_i) begin
                  cnt_d = 32'd0;
                  if (op_q == OpProg) begin
                     state_d = StVrdIssue;
                  end else begin
                     status_d = StatOk;
                     state_d  = StDone;
                  end
               end else if (cnt_q == TimeoutLast) begin
                  cnt_d    = 32'd0;
                  status_d = StatTimeout;
                  state_d  = StDone;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            StVrdIssue: if (!wbm_stall_i) state_d = StVrdAck;
            StVrdAck: begin
               if (wbm_ack_i) begin
                  status_d = (wbm_dat_i == data_q) ? StatOk : StatVerify;
                  state_d  = StDone;
               end
            end
            StDone: begin
               step_d  = 3'd0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cmd_ready_o = (state_q == StIdle);
      busy_o      = (state_q != StIdle);
      done_o      = (state_q == StDone);
      status_o    = status_q;
      wbm_cyc_o   = 1'b0;
      wbm_stb_o   = 1'b0;
      wbm_we_o    = 1'b0;
      wbm_adr_o   = '0;
      wbm_dat_o   = '0;
      case (state_q)
         StIssue: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_adr_o = step_adr;
            wbm_dat_o = step_dat;
         end
         StWaitAck, StVrdAck: wbm_cyc_o = 1'b1;
         // Programs keep the bus cycle open so the verify read follows without a FIFO flush.
         StSettle, StPoll: wbm_cyc_o = (op_q == OpProg);
         StVrdIssue: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_adr_o = addr_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Bench for nor_cmd_seq: table of commands against a wishbone responder with a
// scoreboard of expected bus transactions and completion status.
module tb_nor_cmd_seq;
   localparam int unsigned AB = 26;
   localparam int unsigned DB = 16;
   localparam int unsigned SETTLE = 16;
   localparam logic [31:0] TMO = 32'd100;

   typedef struct {
      logic          we;
      logic [AB-1:0] adr;
      logic [DB-1:0] dat;
   } txn_t;

   typedef struct {
      logic [1:0]    op;
      logic [AB-1:0] addr;
      logic [DB-1:0] data;
      logic [DB-1:0] rdata;
      int            stall_idx;
      int            stall_len;
      int            err_idx;
      int            ry_low;
      logic [1:0]    status;
      int            drops;
      int            lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cop = '0;
   logic [AB-1:0] caddr = '0;
   logic [DB-1:0] cdata = '0;
   logic          done, busy;
   logic [1:0]    status;
   logic          cyc, stb, we;
   logic [AB-1:0] adr;
   logic [DB-1:0] dat;
   logic [DB-1:0] rdat = '0;
   logic          ack = 1'b0, stall = 1'b0, err = 1'b0, ry = 1'b1;

   nor_cmd_seq #(
      .ADDRBITS(AB), .DATABITS(DB), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cop),
      .cmd_addr_i(caddr), .cmd_data_i(cdata),
      .done_o(done), .status_o(status), .busy_o(busy),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat),
      .wbm_dat_i(rdat), .wbm_ack_i(ack), .wbm_stall_i(stall), .wbm_err_i(err),
      .nor_ry_i(ry)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, cur_id = -1;
   int cyc_n = 0;
   txn_t exp_q[$];
   logic [1:0] exp_st_q[$];

   // responder configuration and observations
   logic [DB-1:0] rd_data = '0;
   int stall_idx = -1, stall_left = 0, err_idx = -1, ry_left = 0, txn_idx = 0, drops = 0;
   int last_wack_edge = 0, done_edge = 0;
   bit done_seen = 0;

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL [%0d] %s: got 0x%0h expected 0x%0h", cur_id, name, act, exp);
   endtask

   function automatic txn_t mk(input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
      txn_t t;
      t.we = w; t.adr = a; t.dat = d;
      return t;
   endfunction

   // Expected bus traffic for one command, truncated after an injected error.
   function automatic void push_seq(input logic [1:0] op, input logic [AB-1:0] a,
                                    input logic [DB-1:0] d, input int eidx);
      txn_t s[$];
      if (op == 2'd3) begin
         s.push_back(mk(1'b1, '0, 16'h00F0));
      end else begin
         s.push_back(mk(1'b1, 26'h555, 16'h00AA));
         s.push_back(mk(1'b1, 26'h2AA, 16'h0055));
         if (op == 2'd0) begin
            s.push_back(mk(1'b1, 26'h555, 16'h00A0));
            s.push_back(mk(1'b1, a, d));
            s.push_back(mk(1'b0, a, '0));
         end else begin
            s.push_back(mk(1'b1, 26'h555, 16'h0080));
            s.push_back(mk(1'b1, 26'h555, 16'h00AA));
            s.push_back(mk(1'b1, 26'h2AA, 16'h0055));
            if (op == 2'd1) s.push_back(mk(1'b1, a, 16'h0030));
            else            s.push_back(mk(1'b1, 26'h555, 16'h0010));
         end
      end
      foreach (s[i]) if (eidx < 0 || i <= eidx) exp_q.push_back(s[i]);
   endfunction

   // Wishbone responder / monitor: everything happens on the falling edge.
   initial begin
      bit ack_next = 0, err_next = 0, ack_we = 0, hold_chk = 0, prev_cyc = 0;
      logic [AB-1:0] held_adr = '0;
      txn_t e;
      forever begin
         @(negedge clk);
         ack = 1'b0; err = 1'b0; stall = 1'b0;
         if (hold_chk) begin
            check("stb_held_in_stall", 64'(stb), 64'd1);
            check("adr_held_in_stall", 64'(adr), 64'(held_adr));
            hold_chk = 0;
         end
         if (ack_next) begin
            ack = 1'b1; err = err_next; rdat = rd_data;
            if (ack_we) last_wack_edge = cyc_n + 1;
            ack_next = 0; err_next = 0;
         end
         if (ry_left > 0) begin ry = 1'b0; ry_left--; end
         else ry = 1'b1;
         if (stb) begin
            if (txn_idx == stall_idx && stall_left > 0) begin
               stall = 1'b1; stall_left--; hold_chk = 1; held_adr = adr;
            end else begin
               check("txn_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("txn_we", 64'(we), 64'(e.we));
                  check("txn_adr", 64'(adr), 64'(e.adr));
                  if (e.we) check("txn_dat", 64'(dat), 64'(e.dat));
               end
               ack_next = 1; ack_we = we; err_next = (txn_idx == err_idx);
               txn_idx++;
            end
         end
         if (prev_cyc && !cyc && !done) drops++;
         prev_cyc = cyc;
         if (done) begin
            check("cyc_low_at_done", 64'(cyc), 64'd0);
            check("done_expected", 64'(exp_st_q.size()), 64'd1);
            if (exp_st_q.size() != 0) check("status", 64'(status), 64'(exp_st_q.pop_front()));
            done_seen = 1; done_edge = cyc_n;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [AB-1:0] a, input logic [DB-1:0] d);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      check("ready_before_accept", 64'(cmd_ready), 64'd1);
      valid = 1'b1; cop = op; caddr = a; cdata = d;
      @(negedge clk);
      // Scramble command inputs: the sequencer must work from its latched copy.
      valid = 1'b0; cop = 2'($urandom); caddr = AB'($urandom); cdata = DB'($urandom);
      check("busy_after_accept", 64'(busy), 64'd1);
      check("ready_low_after_accept", 64'(cmd_ready), 64'd0);
      check("cyc_after_accept", 64'(cyc), 64'd1);
      check("stb_after_accept", 64'(stb), 64'd1);
   endtask

   task automatic run_cmd(input vec_t v);
      int n = 0;
      rd_data = v.rdata; stall_idx = v.stall_idx; stall_left = v.stall_len;
      err_idx = v.err_idx; ry_left = v.ry_low; txn_idx = 0; drops = 0;
      done_seen = 0; last_wack_edge = 0;
      push_seq(v.op, v.addr, v.data, v.err_idx);
      exp_st_q.push_back(v.status);
      issue(v.op, v.addr, v.data);
      while (!done_seen && n < 3000) begin @(negedge clk); n++; end
      check("done_within_budget", 64'(done_seen), 64'd1);
      check("all_txns_seen", 64'(exp_q.size()), 64'd0);
      check("cyc_drops_before_done", 64'(drops), 64'(v.drops));
      if (v.lat >= 0) check("done_latency", 64'(done_edge - last_wack_edge), 64'(v.lat));
      @(negedge clk);
      check("done_single_cycle", 64'(done), 64'd0);
      check("ready_after_done", 64'(cmd_ready), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      exp_q.delete();
   endtask

   function automatic vec_t mkv(input logic [1:0] op, input logic [AB-1:0] a,
                                input logic [DB-1:0] d, input logic [DB-1:0] rd,
                                input int si, input int sl, input int ei, input int ryl,
                                input logic [1:0] st, input int dr, input int lat);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.rdata = rd; v.stall_idx = si; v.stall_len = sl;
      v.err_idx = ei; v.ry_low = ryl; v.status = st; v.drops = dr; v.lat = lat;
      return v;
   endfunction

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      int n;
      //            op    addr        data      rdata     stl  len err  ry_low  st    drop lat
      vecs[0] = mkv(2'd0, 26'h001234, 16'hBEEF, 16'hBEEF, -1,  0, -1,  40,     2'd0, 0,   -1);
      vecs[1] = mkv(2'd1, 26'h020000, 16'h0000, 16'h0000,  2,  3, -1,  50,     2'd0, 1,   -1);
      vecs[2] = mkv(2'd2, 26'h000000, 16'h0000, 16'h0000, -1,  0, -1,  100000, 2'd1, 1,   116);
      vecs[3] = mkv(2'd0, 26'h3ABCDE, 16'hBEEF, 16'hBEEE, -1,  0, -1,  0,      2'd3, 0,   19);
      vecs[4] = mkv(2'd3, 26'h1FFFFF, 16'h1234, 16'h0000, -1,  0, -1,  0,      2'd0, 0,   0);
      vecs[5] = mkv(2'd1, 26'h0ABC00, 16'h0000, 16'h0000, -1,  0, -1,  0,      2'd0, 1,   17);
      vecs[6] = mkv(2'd2, 26'h000000, 16'h0000, 16'h0000,  0,  1, -1,  45,     2'd0, 1,   -1);
      vecs[7] = mkv(2'd0, 26'h000777, 16'h5A5A, 16'h5A5A, -1,  0,  1,  0,      2'd2, 0,   0);

      repeat (3) @(negedge clk);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
      check("rst_adr_dat", 64'({adr, dat}), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         cur_id = i;
         run_cmd(vecs[i]);
      end

      // Reset while polling an erase: outputs return to reset values, no completion pulse.
      cur_id = 100;
      rd_data = '0; stall_idx = -1; stall_left = 0; err_idx = -1; ry_left = 100000;
      txn_idx = 0; drops = 0; done_seen = 0;
      push_seq(2'd1, 26'h010000, '0, -1);
      issue(2'd1, 26'h010000, 16'h0000);
      n = 0;
      while (txn_idx < 6 && n < 200) begin @(negedge clk); n++; end
      check("rst_case_txns", 64'(txn_idx), 64'd6);
      repeat (SETTLE + 10) @(negedge clk);
      check("rst_case_busy_in_poll", 64'(busy), 64'd1);
      check("rst_case_status_before", 64'(status), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 64'(cmd_ready), 64'd1);
      check("midrst_busy_done", 64'({busy, done}), 64'd0);
      check("midrst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
      check("midrst_adr_dat", 64'({adr, dat}), 64'd0);
      check("midrst_status", 64'(status), 64'd0);
      repeat (5) @(negedge clk);
      check("midrst_no_done", 64'(done_seen), 64'd0);
      check("midrst_txns_left", 64'(exp_q.size()), 64'd0);

      cur_id = 101;
      run_cmd(mkv(2'd0, 26'h002468, 16'hC0DE, 16'hC0DE, -1, 0, -1, 0, 2'd0, 0, 19));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
